// File: rtl/branch_resolve.sv
// branch_resolve: checks branch outcomes, issues predictor updates and mispredict redirects.
// Define BRANCH_RESOLVE_STATS_EN to build the saturating branch/mispredict counters.
module branch_resolve #(
  parameter int PC_W  = 30,
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [2:0]       ex_branchType,
  input  logic             ex_predictBranchAvail,
  input  logic             ex_branchCommitAtMEM,
  input  logic [IDX_W-1:0] ex_idx,
  input  logic [PC_W-1:0]  ex_NOJPC,
  input  logic [PC_W-1:0]  ex_BPC,
  input  logic             ex_branchAvail,
  input  logic             mem_branchAvail,
  output logic             hold_req,
  output logic             correct_valid,
  output logic [IDX_W-1:0] correct_idx,
  output logic             correct_taken,
  output logic [2:0]       correct_branchType,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_PC,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, SQUASH} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] p_idx;
  logic [2:0] p_type;
  logic p_pred;
  logic [PC_W-1:0] p_nojpc, p_bpc;
  logic ex_br, cap, ex_res, mem_res, res, mis, r_act, r_pred;
  logic [IDX_W-1:0] r_idx;
  logic [2:0] r_type;
  logic [PC_W-1:0] r_nojpc, r_bpc;

  assign ex_br   = ex_valid && |ex_branchType && !stall;
  assign cap     = state == IDLE && ex_br && ex_branchCommitAtMEM;
  assign ex_res  = state == IDLE && ex_br && !ex_branchCommitAtMEM;
  assign mem_res = state == WAIT_MEM && !stall;
  assign res     = ex_res || mem_res;
  assign r_idx   = mem_res ? p_idx : ex_idx;
  assign r_type  = mem_res ? p_type : ex_branchType;
  assign r_pred  = mem_res ? p_pred : ex_predictBranchAvail;
  assign r_act   = mem_res ? mem_branchAvail : ex_branchAvail;
  assign r_nojpc = mem_res ? p_nojpc : ex_NOJPC;
  assign r_bpc   = mem_res ? p_bpc : ex_BPC;
  assign mis     = res && r_act != r_pred;
  // Keeps a second branch out of EX while the single pending slot is occupied.
  assign hold_req = rst && state == WAIT_MEM && ex_valid && |ex_branchType;

  always_comb begin
    state_n = res ? (mis ? SQUASH : IDLE) : cap ? WAIT_MEM : state == SQUASH ? IDLE : state;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      correct_valid      <= 1'b0;
      redirect           <= 1'b0;
      correct_idx        <= '0;
      correct_taken      <= 1'b0;
      correct_branchType <= '0;
      redirect_PC        <= '0;
    end else begin
      correct_valid <= res;
      redirect      <= mis;
      if (res) begin
        correct_idx        <= r_idx;
        correct_taken      <= r_act;
        correct_branchType <= r_type;
      end
      if (mis) redirect_PC <= r_act ? r_bpc : r_nojpc;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      p_idx   <= ex_idx;
      p_type  <= ex_branchType;
      p_pred  <= ex_predictBranchAvail;
      p_nojpc <= ex_NOJPC;
      p_bpc   <= ex_BPC;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (res && !(&branch_cnt)) branch_cnt <= branch_cnt + 1'b1;
      if (mis && !(&mispredict_cnt)) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed + random stimulus against a queue-based reference model with a decoupled monitor.
module tb_branch_resolve;
  localparam int CW = 4;
  localparam int CMAX = 15;
`ifdef BRANCH_RESOLVE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 0, rst = 0, stall = 0, ex_valid = 0, ex_pred = 0, ex_cm = 0, ex_act = 0, mem_act = 0;
  logic [2:0] ex_type = 0;
  logic [5:0] ex_idx = 0;
  logic [29:0] ex_nojpc = 0, ex_bpc = 0;
  logic hold_req, correct_valid, correct_taken, redirect;
  logic [5:0] correct_idx;
  logic [2:0] correct_type;
  logic [29:0] redirect_pc;
  logic [CW-1:0] branch_cnt, mispredict_cnt;
  int total = 0, bad = 0, cyc = 0;

  typedef struct { int cyc; logic [5:0] idx; logic tk; logic [2:0] bt; logic rd; logic [29:0] rpc; int bc; int mc; } exp_t;
  typedef struct { logic [5:0] idx; logic [2:0] bt; logic pred; logic [29:0] nojpc; logic [29:0] bpc; } br_t;
  exp_t sb[$];
  br_t pend[$];
  bit squash = 0;
  int mbc = 0, mmc = 0;

  branch_resolve #(.PC_W(30), .IDX_W(6), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_branchType(ex_type),
    .ex_predictBranchAvail(ex_pred), .ex_branchCommitAtMEM(ex_cm), .ex_idx(ex_idx),
    .ex_NOJPC(ex_nojpc), .ex_BPC(ex_bpc), .ex_branchAvail(ex_act), .mem_branchAvail(mem_act),
    .hold_req(hold_req), .correct_valid(correct_valid), .correct_idx(correct_idx),
    .correct_taken(correct_taken), .correct_branchType(correct_type), .redirect(redirect),
    .redirect_PC(redirect_pc), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic resolve(input br_t b, input logic act);
    exp_t e;
    if (STATS && mbc < CMAX) mbc++;
    if (act != b.pred) begin
      if (STATS && mmc < CMAX) mmc++;
      squash = 1;
    end
    e.cyc = cyc + 1; e.idx = b.idx; e.tk = act; e.bt = b.bt;
    e.rd = act != b.pred; e.rpc = act ? b.bpc : b.nojpc; e.bc = mbc; e.mc = mmc;
    sb.push_back(e);
  endtask

  // Reference behaviour for the inputs about to be sampled at the next edge.
  task automatic model_step();
    br_t b;
    if (!rst) begin
      pend.delete(); squash = 0; mbc = 0; mmc = 0;
    end else if (squash) squash = 0;
    else if (pend.size() > 0) begin
      if (!stall) begin
        resolve(pend[0], mem_act);
        pend.delete();
      end
    end else if (ex_valid && ex_type != 0 && !stall) begin
      b.idx = ex_idx; b.bt = ex_type; b.pred = ex_pred; b.nojpc = ex_nojpc; b.bpc = ex_bpc;
      if (ex_cm) pend.push_back(b);
      else resolve(b, ex_act);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic [2:0] t, input logic p,
                       input logic cm, input logic [5:0] ix, input logic [29:0] nj, input logic [29:0] bp,
                       input logic a, input logic ma);
    logic eh;
    @(posedge clk); #1;
    rst = r; stall = s; ex_valid = v; ex_type = t; ex_pred = p; ex_cm = cm; ex_idx = ix;
    ex_nojpc = nj; ex_bpc = bp; ex_act = a; mem_act = ma;
    eh = r && pend.size() > 0 && !squash && v && t != 0;
    model_step();
    #1 chk("hold_req", 32'(hold_req), 32'(eh));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int ebc = 0, emc = 0;
  initial begin
    logic was_rst;
    exp_t e;
    forever begin
      @(posedge clk);
      was_rst = !rst;
      #2;
      if (was_rst) begin
        ebc = 0; emc = 0;
        chk("rst_valid", 32'(correct_valid), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_idx", 32'(correct_idx), 0);
        chk("rst_taken", 32'(correct_taken), 0);
        chk("rst_type", 32'(correct_type), 0);
        chk("rst_pc", 32'(redirect_pc), 0);
      end else if (correct_valid) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) chk("unexpected_strobe", 1, 0);
        else begin
          e = sb.pop_front();
          ebc = e.bc; emc = e.mc;
          chk("idx", 32'(correct_idx), 32'(e.idx));
          chk("taken", 32'(correct_taken), 32'(e.tk));
          chk("type", 32'(correct_type), 32'(e.bt));
          chk("redirect", 32'(redirect), 32'(e.rd));
          if (e.rd) chk("redirect_pc", 32'(redirect_pc), 32'(e.rpc));
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          void'(sb.pop_front());
          chk("missing_strobe", 0, 1);
        end
        chk("redirect_idle", 32'(redirect), 0);
      end
      chk("branch_cnt", 32'(branch_cnt), 32'(ebc));
      chk("mispredict_cnt", 32'(mispredict_cnt), 32'(emc));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //      r s v t p cm ix  nojpc  bpc    a ma
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 0, 1, 1, 1, 0, 5, 30'h3f, 30'h100, 1, 0);
    idle(1);
    drive(1, 0, 1, 2, 0, 0, 9, 30'h41, 30'h80, 1, 0);
    drive(1, 0, 1, 3, 0, 0, 7, 30'h11, 30'h22, 1, 0);
    idle(2);
    drive(1, 0, 1, 4, 1, 1, 12, 30'h200, 30'h300, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(1, 0, 1, 1, 0, 1, 20, 30'h500, 30'h600, 0, 0);
    drive(1, 1, 1, 5, 1, 0, 21, 30'h10, 30'h20, 1, 1);
    drive(1, 1, 1, 5, 1, 0, 21, 30'h10, 30'h20, 1, 1);
    drive(1, 0, 1, 5, 1, 0, 21, 30'h10, 30'h20, 1, 0);
    drive(1, 0, 1, 5, 1, 0, 21, 30'h10, 30'h20, 1, 0);
    idle(2);
    drive(1, 0, 1, 6, 0, 1, 33, 30'h700, 30'h800, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      drive(1, 0, 1, 7, 1, 0, 6'(i), 30'(i), 30'(i + 100), 0, 0);
      idle(1);
    end
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(63) != 0, $urandom_range(3) == 0, $urandom_range(1) == 1,
            $urandom_range(3) == 0 ? 3'd0 : 3'($urandom_range(7)), 1'($urandom), 1'($urandom),
            6'($urandom), 30'($urandom), 30'($urandom), 1'($urandom), 1'($urandom));
    idle(3);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
